// File: rtl/fetch_pkg.sv
// fetch_pkg: shared reset PC, NOP encoding and prefetch entry type for the fetch front end
package fetch_pkg;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry prefetch FIFO of {instr, pc}; flush wins over push
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_push,
    input  fetch_entry_t            i_data,
    input  logic                    i_pop,
    input  logic                    i_flush,
    output logic [$clog2(DEPTH):0]  o_count,
    output fetch_entry_t            o_head
);
    localparam int AW = $clog2(DEPTH);
    fetch_entry_t r_mem [DEPTH];
    logic [AW-1:0] r_rd;
    logic [AW-1:0] r_wr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;
    assign w_push  = i_push && !i_flush;
    assign w_pop   = i_pop && !i_flush && (r_count != '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd];
    // storage and pointers; entries reset to {0, RESET_PC} so the idle head is well defined
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '{instr: 32'h0, pc: RESET_PC};
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_mem[r_wr] <= i_data;
            r_wr    <= w_push ? r_wr + 1'b1 : r_wr;
            r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner, credit-limited imem requester and prefetch buffer; FETCH_PERF_EN adds perf counters
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_instr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        fetch_valid,
    output logic [31:0] fetch_instr,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_pc_plus_4
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_dropped
`endif
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [31:0]  r_pc;
    logic [31:0]  r_resp_pc;
    logic [CW-1:0] r_out;
    logic [CW-1:0] r_stale;
    logic [CW-1:0] w_count;
    logic [CW-1:0] w_out_nx;
    logic [31:0]  w_target;
    logic         w_accept;
    logic         w_resp;
    logic         w_drop;
    logic         w_push;
    logic         w_pop;
    fetch_entry_t w_entry;
    fetch_entry_t w_head;
    assign w_target        = {redirect_pc[31:2], 2'b00};
    assign imem_req_valid  = !reset && (({1'b0, w_count} + {1'b0, r_out}) < (CW+1)'(DEPTH));
    assign imem_req_addr   = r_pc;
    assign w_accept        = imem_req_valid && imem_req_ready;
    assign w_resp          = imem_resp_valid && (r_out != '0);
    assign w_drop          = w_resp && (redirect || (r_stale != '0));
    assign w_push          = w_resp && !w_drop;
    assign fetch_valid     = w_count != '0;
    assign w_pop           = fetch_valid && !stall && !redirect;
    assign w_out_nx        = r_out + CW'(w_accept) - CW'(w_resp);
    assign w_entry         = '{instr: imem_resp_instr, pc: r_resp_pc};
    assign fetch_instr     = w_head.instr;
    assign fetch_pc        = w_head.pc;
    assign fetch_pc_plus_4 = w_head.pc + 32'd4;
    fetch_fifo #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) u_fifo (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_pop),
        .i_flush (redirect),
        .o_count (w_count),
        .o_head  (w_head)
    );
    // request PC, response PC, in-flight and wrong-path bookkeeping; redirect marks everything in flight stale
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_resp_pc <= RESET_PC;
            r_out     <= '0;
            r_stale   <= '0;
        end else begin
            r_out     <= w_out_nx;
            r_pc      <= redirect ? w_target : w_accept ? r_pc + 32'd4 : r_pc;
            r_resp_pc <= redirect ? w_target : w_push ? r_resp_pc + 32'd4 : r_resp_pc;
            r_stale   <= redirect ? w_out_nx : w_drop ? r_stale - 1'b1 : r_stale;
        end
    end
    a_resp_has_req: assert property (@(posedge clk) disable iff (reset) imem_resp_valid |-> (r_out != '0));
`ifdef FETCH_PERF_EN
    // free-running event counters, wrapping at 2^32
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched      <= '0;
            perf_stall_cycles <= '0;
            perf_dropped      <= '0;
        end else begin
            perf_fetched      <= perf_fetched + 32'(w_pop);
            perf_stall_cycles <= perf_stall_cycles + 32'(fetch_valid && stall);
            perf_dropped      <= perf_dropped + 32'(w_drop);
        end
    end
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed checks of fetch_unit against a queued imem model and an in-order PC stream
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_instr = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        stall = 1'b0;
    logic        fetch_valid;
    logic [31:0] fetch_instr;
    logic [31:0] fetch_pc;
    logic [31:0] fetch_pc_plus_4;

    always #5 clk = ~clk;

    fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_instr (imem_resp_instr),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .stall           (stall),
        .fetch_valid     (fetch_valid),
        .fetch_instr     (fetch_instr),
        .fetch_pc        (fetch_pc),
        .fetch_pc_plus_4 (fetch_pc_plus_4)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          lat = 1;
    int          pops = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] q_addr [$];
    int          q_due [$];

    function automatic logic [31:0] word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one clock: sample at negedge (stream check on pops), advance imem model after posedge, drive response
    task automatic tick();
        logic        acc;
        logic        rsp;
        logic        rs;
        logic [31:0] a;
        @(negedge clk);
        rs  = reset;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        rsp = imem_resp_valid;
        if (fetch_valid && !stall && !redirect && !reset) begin
            chk("stream_pc", fetch_pc, exp_pc);
            chk("stream_instr", fetch_instr, word(exp_pc));
            chk("stream_pc_plus_4", fetch_pc_plus_4, exp_pc + 32'd4);
            exp_pc += 32'd4;
            pops++;
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rs) begin
            q_addr.delete();
            q_due.delete();
        end else begin
            if (rsp) begin
                void'(q_addr.pop_front());
                void'(q_due.pop_front());
            end
            if (acc) begin
                q_addr.push_back(a);
                q_due.push_back(cyc - 1 + lat);
            end
        end
        imem_resp_valid = (q_addr.size() != 0) && (q_due[0] <= cyc);
        imem_resp_instr = imem_resp_valid ? word(q_addr[0]) : 32'h0;
        #1;
    endtask

    initial begin
        int p0;
        int n;
        repeat (3) tick();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_fetch_valid", 32'(fetch_valid), 32'd0);
        chk("rst_fetch_instr", fetch_instr, 32'h0);
        chk("rst_fetch_pc", fetch_pc, 32'h0);
        chk("rst_fetch_pc_plus_4", fetch_pc_plus_4, 32'h4);

        reset = 1'b0;
        exp_pc = 32'h0;
        tick();
        chk("first_cycle_valid", 32'(fetch_valid), 32'd0);
        tick();
        chk("first_valid", 32'(fetch_valid), 32'd1);
        chk("seq_pc0", fetch_pc, 32'h0);
        chk("seq_pc0_plus_4", fetch_pc_plus_4, 32'h4);
        tick();
        chk("seq_pc4", fetch_pc, 32'h4);
        tick();
        chk("seq_pc8", fetch_pc, 32'h8);

        stall = 1'b1;
        repeat (3) tick();
        chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
        chk("stall_head_valid", 32'(fetch_valid), 32'd1);
        chk("stall_head_pc", fetch_pc, 32'h8);
        repeat (3) tick();
        stall = 1'b0;
        chk("stall_release_pc", fetch_pc, 32'h8);
        tick();
        chk("after_stall_pc_c", fetch_pc, 32'hC);
        tick();
        chk("after_stall_pc_10", fetch_pc, 32'h10);

        redirect = 1'b1;
        redirect_pc = 32'h202;
        exp_pc = 32'h200;
        tick();
        redirect = 1'b0;
        chk("redir1_valid_n1", 32'(fetch_valid), 32'd0);
        chk("redir1_req_valid_n1", 32'(imem_req_valid), 32'd1);
        chk("redir1_req_addr_n1", imem_req_addr, 32'h200);
        tick();
        chk("redir1_valid_n2", 32'(fetch_valid), 32'd0);
        tick();
        chk("redir1_first_valid", 32'(fetch_valid), 32'd1);
        chk("redir1_first_pc", fetch_pc, 32'h200);
        chk("redir1_first_instr", fetch_instr, word(32'h200));

        lat = 2;
        repeat (8) tick();
        chk("redir2_outstanding", 32'(q_addr.size()), 32'd2);
        chk("redir2_req_valid", 32'(imem_req_valid), 32'd1);
        redirect = 1'b1;
        redirect_pc = 32'h103;
        exp_pc = 32'h100;
        tick();
        redirect = 1'b0;
        chk("redir2_valid_n1", 32'(fetch_valid), 32'd0);
        chk("redir2_req_valid_n1", 32'(imem_req_valid), 32'd1);
        chk("redir2_req_addr_n1", imem_req_addr, 32'h100);
        tick();
        tick();
        chk("redir2_valid_n3", 32'(fetch_valid), 32'd0);
        tick();
        chk("redir2_first_valid", 32'(fetch_valid), 32'd1);
        chk("redir2_first_pc", fetch_pc, 32'h100);
        chk("redir2_first_plus_4", fetch_pc_plus_4, 32'h104);

        lat = 3;
        p0 = pops;
        n = 0;
        while ((pops - p0) < 100 && n < 3000) begin
            imem_req_ready = 1'($urandom_range(0, 1));
            stall = ($urandom_range(0, 3) == 0);
            tick();
            chk("outstanding_le_4", 32'(q_addr.size() <= 4), 32'd1);
            n++;
        end
        chk("lat3_100_fetched", 32'((pops - p0) >= 100), 32'd1);
        imem_req_ready = 1'b1;
        stall = 1'b0;

        lat = 1;
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        exp_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        n = 0;
        while (!(fetch_valid && fetch_pc == 32'hFFFF_FFFC) && n < 40) begin
            tick();
            n++;
        end
        chk("wrap_top_pc", fetch_pc, 32'hFFFF_FFFC);
        chk("wrap_plus_4", fetch_pc_plus_4, 32'h0);
        tick();
        n = 0;
        while (!fetch_valid && n < 20) begin
            tick();
            n++;
        end
        chk("wrap_next_pc", fetch_pc, 32'h0);
        chk("wrap_next_instr", fetch_instr, word(32'h0));
        repeat (3) tick();

        reset = 1'b1;
        tick();
        chk("midrst_valid", 32'(fetch_valid), 32'd0);
        chk("midrst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("midrst_req_addr", imem_req_addr, 32'h0);
        chk("midrst_fetch_pc", fetch_pc, 32'h0);
        reset = 1'b0;
        exp_pc = 32'h0;
        tick();
        chk("midrst_valid_c1", 32'(fetch_valid), 32'd0);
        tick();
        chk("midrst_refetch_valid", 32'(fetch_valid), 32'd1);
        chk("midrst_refetch_pc", fetch_pc, 32'h0);
        repeat (5) tick();
        chk("midrst_stream_pc", fetch_pc, 32'h14);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
